// File: rtl/cpu_pkg.sv
// Shared pipeline definitions for the five-stage MIPS core: default field
// widths, control-bundle bit positions and the all-zero bubble bundles.
package cpu_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int REG_W_DEF   = 5;
  localparam int ALUOP_W_DEF = 4;

  localparam int MEM_W = 3;
  localparam int WB_W  = 2;

  // EX bundle is {alu_src, alu_op, reg_dst}; alu_src position moves with ALUOP_W.
  localparam int EX_REG_DST   = 0;
  localparam int EX_ALUOP_LSB = 1;

  function automatic int ex_alu_src_pos(input int aluop_w);
    return aluop_w + 1;
  endfunction

  localparam int EX_ALU_SRC = ex_alu_src_pos(ALUOP_W_DEF);

  // MEM bundle is {branch, mem_write, mem_read}.
  localparam int MEM_BRANCH = 2;
  localparam int MEM_WRITE  = 1;
  localparam int MEM_READ   = 0;

  // WB bundle is {mem_to_reg, reg_write}.
  localparam int WB_MEM_TO_REG = 1;
  localparam int WB_REG_WRITE  = 0;

  localparam logic [MEM_W-1:0] MEM_BUBBLE = 3'b000;
  localparam logic [WB_W-1:0]  WB_BUBBLE  = 2'b00;

endpackage

// File: rtl/pipe_reg_en_clr.sv
// Width-parameterised pipeline register: async active-low reset, synchronous
// clear (highest priority after reset), then enable-gated load.
module pipe_reg_en_clr #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Storage: reset to zero, clear to zero, load on enable, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= {W{1'b0}};
    end else if (clr) begin
      q <= {W{1'b0}};
    end else if (en) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with valid bit, stall/flush, load-use hazard
// detection with automatic bubble insertion, and saturating bubble/stall counters.
module id_ex_pipe_reg
  import cpu_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int REG_W   = REG_W_DEF,
  parameter int ALUOP_W = ALUOP_W_DEF,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [DATA_W-1:0]    in_pc4,
  input  logic [DATA_W-1:0]    in_rd1,
  input  logic [DATA_W-1:0]    in_rd2,
  input  logic [DATA_W-1:0]    in_imm,
  input  logic [REG_W-1:0]     in_rs,
  input  logic [REG_W-1:0]     in_rt,
  input  logic [REG_W-1:0]     in_rd,
  input  logic                 in_uses_rt,
  input  logic                 in_alu_src,
  input  logic                 in_reg_dst,
  input  logic                 in_branch,
  input  logic                 in_mem_write,
  input  logic                 in_mem_read,
  input  logic                 in_mem_to_reg,
  input  logic                 in_reg_write,
  input  logic [ALUOP_W-1:0]   in_alu_op,
  output logic                 out_valid,
  output logic [DATA_W-1:0]    out_pc4,
  output logic [DATA_W-1:0]    out_rd1,
  output logic [DATA_W-1:0]    out_rd2,
  output logic [DATA_W-1:0]    out_imm,
  output logic [REG_W-1:0]     out_rs,
  output logic [REG_W-1:0]     out_rt,
  output logic [REG_W-1:0]     out_rd,
  output logic [ALUOP_W+1:0]   out_ex,
  output logic [MEM_W-1:0]     out_mem,
  output logic [WB_W-1:0]      out_wb,
  output logic                 hazard_stall,
  output logic [CNT_W-1:0]     bubble_cnt,
  output logic [CNT_W-1:0]     stall_cnt
);

  localparam int EX_W     = ALUOP_W + 2;
  localparam int EX_SRC   = ex_alu_src_pos(ALUOP_W);
  localparam int CTRL_W   = 1 + EX_W + MEM_W + WB_W;
  localparam int DBUS_W   = 4 * DATA_W + 3 * REG_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [EX_W-1:0]   ex_d_s;
  logic [MEM_W-1:0]  mem_d_s;
  logic [WB_W-1:0]   wb_d_s;
  logic [CTRL_W-1:0] ctrl_d_s;
  logic [CTRL_W-1:0] ctrl_q_s;
  logic [DBUS_W-1:0] data_d_s;
  logic [DBUS_W-1:0] data_q_s;
  logic              rt_match_s;
  logic              hazard_s;
  logic              bubble_s;
  logic              stall_evt_s;
  logic [CNT_W-1:0]  bubble_cnt_r;
  logic [CNT_W-1:0]  stall_cnt_r;

  // Control bundles from decode; an invalid decode slot contributes no control.
  always_comb begin
    ex_d_s  = {EX_W{1'b0}};
    mem_d_s = MEM_BUBBLE;
    wb_d_s  = WB_BUBBLE;
    if (in_valid) begin
      ex_d_s[EX_SRC]                        = in_alu_src;
      ex_d_s[EX_ALUOP_LSB +: ALUOP_W]       = in_alu_op;
      ex_d_s[EX_REG_DST]                    = in_reg_dst;
      mem_d_s[MEM_BRANCH]                   = in_branch;
      mem_d_s[MEM_WRITE]                    = in_mem_write;
      mem_d_s[MEM_READ]                     = in_mem_read;
      wb_d_s[WB_MEM_TO_REG]                 = in_mem_to_reg;
      wb_d_s[WB_REG_WRITE]                  = in_reg_write;
    end else begin
      ex_d_s  = {EX_W{1'b0}};
      mem_d_s = MEM_BUBBLE;
      wb_d_s  = WB_BUBBLE;
    end
  end

  assign ctrl_d_s = {in_valid, ex_d_s, mem_d_s, wb_d_s};
  assign data_d_s = {in_pc4, in_rd1, in_rd2, in_imm, in_rs, in_rt, in_rd};

  // Load-use detection: a load in EX whose nonzero rt feeds the decode instruction.
  always_comb begin
    rt_match_s = (out_rt == in_rs) | (in_uses_rt & (out_rt == in_rt));
    hazard_s   = out_valid & out_mem[MEM_READ] & (out_rt != {REG_W{1'b0}})
               & in_valid & rt_match_s & ~flush;
  end

  assign hazard_stall = hazard_s;
  // Flush always bubbles; a hazard bubbles only once the downstream hold lifts.
  assign bubble_s     = flush | (~stall & hazard_s);
  assign stall_evt_s  = stall & ~flush;

  pipe_reg_en_clr #(.W(CTRL_W)) u_ctrl_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (~stall),
    .clr   (bubble_s),
    .d     (ctrl_d_s),
    .q     (ctrl_q_s)
  );

  pipe_reg_en_clr #(.W(DBUS_W)) u_data_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (~stall & ~bubble_s),
    .clr   (1'b0),
    .d     (data_d_s),
    .q     (data_q_s)
  );

  assign {out_valid, out_ex, out_mem, out_wb} = ctrl_q_s;
  assign {out_pc4, out_rd1, out_rd2, out_imm, out_rs, out_rt, out_rd} = data_q_s;

  // Saturating bubble and stall event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt_r <= {CNT_W{1'b0}};
      stall_cnt_r  <= {CNT_W{1'b0}};
    end else begin
      if (bubble_s && (bubble_cnt_r != CNT_MAX)) begin
        bubble_cnt_r <= bubble_cnt_r + CNT_ONE;
      end else begin
        bubble_cnt_r <= bubble_cnt_r;
      end
      if (stall_evt_s && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

  assign bubble_cnt = bubble_cnt_r;
  assign stall_cnt  = stall_cnt_r;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed self-checking bench for id_ex_pipe_reg. A second instance with a
// 2-bit counter width shares the stimulus to exercise counter saturation.
module tb_id_ex_pipe_reg;

  logic        clk;
  logic        rst_n;
  logic        stall, flush, in_valid;
  logic [31:0] in_pc4, in_rd1, in_rd2, in_imm;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic        in_uses_rt, in_alu_src, in_reg_dst, in_branch;
  logic        in_mem_write, in_mem_read, in_mem_to_reg, in_reg_write;
  logic [3:0]  in_alu_op;

  logic        out_valid;
  logic [31:0] out_pc4, out_rd1, out_rd2, out_imm;
  logic [4:0]  out_rs, out_rt, out_rd;
  logic [5:0]  out_ex;
  logic [2:0]  out_mem;
  logic [1:0]  out_wb;
  logic        hazard_stall;
  logic [15:0] bubble_cnt, stall_cnt;

  logic        s_valid;
  logic [31:0] s_pc4, s_rd1, s_rd2, s_imm;
  logic [4:0]  s_rs, s_rt, s_rd;
  logic [5:0]  s_ex;
  logic [2:0]  s_mem;
  logic [1:0]  s_wb;
  logic        s_hazard;
  logic [1:0]  s_bubble_cnt, s_stall_cnt;

  int errors = 0;
  int checks = 0;

  id_ex_pipe_reg dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_pc4(in_pc4), .in_rd1(in_rd1), .in_rd2(in_rd2), .in_imm(in_imm),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_uses_rt(in_uses_rt),
    .in_alu_src(in_alu_src), .in_reg_dst(in_reg_dst), .in_branch(in_branch),
    .in_mem_write(in_mem_write), .in_mem_read(in_mem_read),
    .in_mem_to_reg(in_mem_to_reg), .in_reg_write(in_reg_write), .in_alu_op(in_alu_op),
    .out_valid(out_valid), .out_pc4(out_pc4), .out_rd1(out_rd1), .out_rd2(out_rd2),
    .out_imm(out_imm), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
    .out_ex(out_ex), .out_mem(out_mem), .out_wb(out_wb), .hazard_stall(hazard_stall),
    .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
  );

  id_ex_pipe_reg #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_pc4(in_pc4), .in_rd1(in_rd1), .in_rd2(in_rd2), .in_imm(in_imm),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_uses_rt(in_uses_rt),
    .in_alu_src(in_alu_src), .in_reg_dst(in_reg_dst), .in_branch(in_branch),
    .in_mem_write(in_mem_write), .in_mem_read(in_mem_read),
    .in_mem_to_reg(in_mem_to_reg), .in_reg_write(in_reg_write), .in_alu_op(in_alu_op),
    .out_valid(s_valid), .out_pc4(s_pc4), .out_rd1(s_rd1), .out_rd2(s_rd2),
    .out_imm(s_imm), .out_rs(s_rs), .out_rt(s_rt), .out_rd(s_rd),
    .out_ex(s_ex), .out_mem(s_mem), .out_wb(s_wb), .hazard_stall(s_hazard),
    .bubble_cnt(s_bubble_cnt), .stall_cnt(s_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
    in_pc4 = 32'h0; in_rd1 = 32'h0; in_rd2 = 32'h0; in_imm = 32'h0;
    in_rs = 5'd0; in_rt = 5'd0; in_rd = 5'd0; in_uses_rt = 1'b0;
    in_alu_src = 1'b0; in_reg_dst = 1'b0; in_branch = 1'b0; in_mem_write = 1'b0;
    in_mem_read = 1'b0; in_mem_to_reg = 1'b0; in_reg_write = 1'b0; in_alu_op = 4'h0;
  endtask

  // lw rt, imm(rs): alu_src=1, alu_op=add(2), mem_read, mem_to_reg, reg_write
  task automatic drive_lw(input logic [4:0] rs, input logic [4:0] rt);
    idle_inputs();
    in_valid = 1'b1; in_pc4 = 32'h0000_0200; in_rs = rs; in_rt = rt; in_rd = 5'd0;
    in_imm = 32'h4; in_alu_src = 1'b1; in_alu_op = 4'b0010; in_mem_read = 1'b1;
    in_mem_to_reg = 1'b1; in_reg_write = 1'b1; in_uses_rt = 1'b0;
  endtask

  // R-type add rd, rs, rt: reg_dst=1, alu_op=2, reg_write
  task automatic drive_add(input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic uses_rt);
    idle_inputs();
    in_valid = 1'b1; in_pc4 = 32'h0000_0204; in_rs = rs; in_rt = rt; in_rd = rd;
    in_rd1 = 32'h11; in_rd2 = 32'h22; in_reg_dst = 1'b1; in_alu_op = 4'b0010;
    in_reg_write = 1'b1; in_uses_rt = uses_rt;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    idle_inputs();
    in_valid = 1'b1; in_pc4 = 32'h0000_0ABC; in_reg_write = 1'b1;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_pc4 !== 32'h0000_0ABC || bubble_cnt !== 16'd1) begin
      errors++;
      $display("FAIL reset_setup valid=%b pc4=%h bcnt=%0d exp 1 00000abc 1", out_valid, out_pc4, bubble_cnt);
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_pc4 !== 32'h0 || out_wb !== 2'b00 || out_ex !== 6'd0) begin
      errors++;
      $display("FAIL reset_async valid=%b pc4=%h wb=%b ex=%b exp all zero", out_valid, out_pc4, out_wb, out_ex);
    end
    checks++;
    if (bubble_cnt !== 16'd0 || stall_cnt !== 16'd0 || hazard_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_cnt bcnt=%0d scnt=%0d hz=%b exp 0 0 0", bubble_cnt, stall_cnt, hazard_stall);
    end
    #1 rst_n = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_pc4 !== 32'h0000_0ABC) begin
      errors++;
      $display("FAIL reset_first_load valid=%b pc4=%h exp 1 00000abc", out_valid, out_pc4);
    end
  endtask

  task automatic test_pass_through();
    do_reset();
    idle_inputs();
    in_valid = 1'b1; in_pc4 = 32'h0000_0104; in_alu_op = 4'b0010; in_reg_write = 1'b1;
    in_rd1 = 32'hDEAD_BEEF; in_rd2 = 32'h1234_5678; in_imm = 32'hFFFF_FFF0;
    in_rs = 5'd3; in_rt = 5'd4; in_rd = 5'd5;
    step();
    checks++;
    if (out_pc4 !== 32'h0000_0104 || out_ex[4:1] !== 4'd2 || out_wb !== 2'b01 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL pass_ctrl pc4=%h aluop=%0d wb=%b valid=%b exp 104 2 01 1", out_pc4, out_ex[4:1], out_wb, out_valid);
    end
    checks++;
    if (out_rd1 !== 32'hDEAD_BEEF || out_rd2 !== 32'h1234_5678 || out_imm !== 32'hFFFF_FFF0
        || out_rs !== 5'd3 || out_rt !== 5'd4 || out_rd !== 5'd5 || out_ex !== 6'b000100) begin
      errors++;
      $display("FAIL pass_data rd1=%h rd2=%h imm=%h rs=%0d rt=%0d rd=%0d ex=%b",
               out_rd1, out_rd2, out_imm, out_rs, out_rt, out_rd, out_ex);
    end
    // invalid decode slot loads zero control
    idle_inputs();
    in_valid = 1'b0; in_reg_write = 1'b1; in_mem_read = 1'b1; in_alu_op = 4'hF;
    step();
    checks++;
    if (out_valid !== 1'b0 || out_wb !== 2'b00 || out_mem !== 3'b000 || out_ex !== 6'd0) begin
      errors++;
      $display("FAIL pass_invalid valid=%b wb=%b mem=%b ex=%b exp zeros", out_valid, out_wb, out_mem, out_ex);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    drive_lw(5'd9, 5'd8);
    step();
    drive_add(5'd8, 5'd10, 5'd11, 1'b1);
    #1;
    checks++;
    if (hazard_stall !== 1'b1) begin
      errors++;
      $display("FAIL lu_detect hazard_stall=%b exp 1", hazard_stall);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || out_ex !== 6'd0 || out_mem !== 3'd0 || out_wb !== 2'd0 || out_rt !== 5'd8) begin
      errors++;
      $display("FAIL lu_bubble valid=%b ex=%b mem=%b wb=%b rt=%0d exp 0 0 0 0 8", out_valid, out_ex, out_mem, out_wb, out_rt);
    end
    checks++;
    if (bubble_cnt !== 16'd1 || hazard_stall !== 1'b0) begin
      errors++;
      $display("FAIL lu_count bcnt=%0d hz=%b exp 1 0", bubble_cnt, hazard_stall);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_rd !== 5'd11 || out_rs !== 5'd8 || out_wb !== 2'b01
        || out_ex !== 6'b000101 || bubble_cnt !== 16'd1) begin
      errors++;
      $display("FAIL lu_reload valid=%b rd=%0d rs=%0d wb=%b ex=%b bcnt=%0d", out_valid, out_rd, out_rs, out_wb, out_ex, bubble_cnt);
    end
  endtask

  task automatic test_hazard_boundaries();
    do_reset();
    drive_lw(5'd1, 5'd0);
    step();
    drive_add(5'd0, 5'd2, 5'd3, 1'b1);
    #1;
    checks++;
    if (hazard_stall !== 1'b0) begin
      errors++;
      $display("FAIL rt0_hazard hazard_stall=%b exp 0", hazard_stall);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || bubble_cnt !== 16'd0 || out_rd !== 5'd3) begin
      errors++;
      $display("FAIL rt0_nobubble valid=%b bcnt=%0d rd=%0d exp 1 0 3", out_valid, bubble_cnt, out_rd);
    end
    // rt match only counts when the consumer actually reads rt
    drive_lw(5'd1, 5'd5);
    step();
    drive_add(5'd1, 5'd5, 5'd6, 1'b0);
    #1;
    checks++;
    if (hazard_stall !== 1'b0) begin
      errors++;
      $display("FAIL rt_unused hazard_stall=%b exp 0", hazard_stall);
    end
    in_uses_rt = 1'b1;
    #1;
    checks++;
    if (hazard_stall !== 1'b1) begin
      errors++;
      $display("FAIL rt_used hazard_stall=%b exp 1", hazard_stall);
    end
    flush = 1'b1;
    #1;
    checks++;
    if (hazard_stall !== 1'b0) begin
      errors++;
      $display("FAIL hz_flush_mask hazard_stall=%b exp 0", hazard_stall);
    end
  endtask

  task automatic test_stall_flush();
    do_reset();
    idle_inputs();
    in_valid = 1'b1; in_pc4 = 32'h0000_0200; in_reg_write = 1'b1; in_rd = 5'd7;
    step();
    idle_inputs();
    in_valid = 1'b1; in_pc4 = 32'h0000_0300; in_mem_write = 1'b1; in_rd = 5'd9;
    stall = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_pc4 !== 32'h0000_0200 || out_wb !== 2'b01
          || out_rd !== 5'd7 || stall_cnt !== 16'(i)) begin
        errors++;
        $display("FAIL stall_hold%0d valid=%b pc4=%h wb=%b rd=%0d scnt=%0d", i, out_valid, out_pc4, out_wb, out_rd, stall_cnt);
      end
    end
    flush = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0 || out_wb !== 2'b00 || out_mem !== 3'b000 || out_pc4 !== 32'h0000_0200
        || stall_cnt !== 16'd3 || bubble_cnt !== 16'd1) begin
      errors++;
      $display("FAIL stall_flush valid=%b wb=%b mem=%b pc4=%h scnt=%0d bcnt=%0d", out_valid, out_wb, out_mem, out_pc4, stall_cnt, bubble_cnt);
    end
    // stall together with a pending hazard: hold, no bubble until stall drops
    flush = 1'b0; stall = 1'b0;
    drive_lw(5'd1, 5'd12);
    step();
    drive_add(5'd12, 5'd2, 5'd13, 1'b1);
    stall = 1'b1;
    step();
    checks++;
    if (hazard_stall !== 1'b1 || out_valid !== 1'b1 || out_mem !== 3'b001 || bubble_cnt !== 16'd1) begin
      errors++;
      $display("FAIL stall_hazard hz=%b valid=%b mem=%b bcnt=%0d exp 1 1 001 1", hazard_stall, out_valid, out_mem, bubble_cnt);
    end
    stall = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0 || bubble_cnt !== 16'd2 || stall_cnt !== 16'd4) begin
      errors++;
      $display("FAIL stall_hazard_release valid=%b bcnt=%0d scnt=%0d exp 0 2 4", out_valid, bubble_cnt, stall_cnt);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_sat;
    do_reset();
    idle_inputs();
    flush = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      exp_sat = (i >= 3) ? 2'd3 : 2'(i);
      checks++;
      if (s_bubble_cnt !== exp_sat) begin
        errors++;
        $display("FAIL sat_bubble%0d got %0d exp %0d", i, s_bubble_cnt, exp_sat);
      end
    end
    checks++;
    if (bubble_cnt !== 16'd5) begin
      errors++;
      $display("FAIL wide_bubble got %0d exp 5", bubble_cnt);
    end
    flush = 1'b0; stall = 1'b1;
    for (int i = 1; i <= 4; i++) step();
    checks++;
    if (s_stall_cnt !== 2'd3 || stall_cnt !== 16'd4) begin
      errors++;
      $display("FAIL sat_stall got %0d/%0d exp 3/4", s_stall_cnt, stall_cnt);
    end
    stall = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #12 rst_n = 1'b1;
    test_reset();
    test_pass_through();
    test_load_use();
    test_hazard_boundaries();
    test_stall_flush();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
